// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the unidad_control FSM and its opcode decoder
package ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_LDI   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  localparam logic [1:0] ACC_SEL_ALU = 2'd0;
  localparam logic [1:0] ACC_SEL_MEM = 2'd1;
  localparam logic [1:0] ACC_SEL_IMM = 2'd2;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_TO   = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_LATCH  = 4'd2,
    ST_DECODE = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_WB     = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_HALTED = 4'd7,
    ST_ERROR  = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP   = 4'd0,
    CL_LOAD  = 4'd1,
    CL_STORE = 4'd2,
    CL_ALU   = 4'd3,
    CL_LDI   = 4'd4,
    CL_JMP   = 4'd5,
    CL_JZ    = 4'd6,
    CL_HALT  = 4'd7,
    CL_ILL   = 4'd8
  } cls_t;

endpackage

// File: rtl/unidad_control_decodificador.sv
// rtl/unidad_control_decodificador.sv - combinational opcode to class/alu_op/legal decoder
module decodificador
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output cls_t       cls,
  output logic [2:0] alu_op,
  output logic       legal
);

  always_comb begin
    cls    = CL_ILL;
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (opcode)
      OP_NOP:   cls = CL_NOP;
      OP_LOAD:  cls = CL_LOAD;
      OP_STORE: cls = CL_STORE;
      OP_ADD:   begin cls = CL_ALU; alu_op = ALU_ADD; end
      OP_SUB:   begin cls = CL_ALU; alu_op = ALU_SUB; end
      OP_AND:   begin cls = CL_ALU; alu_op = ALU_AND; end
      OP_OR:    begin cls = CL_ALU; alu_op = ALU_OR;  end
      OP_XOR:   begin cls = CL_ALU; alu_op = ALU_XOR; end
      OP_LDI:   cls = CL_LDI;
      OP_JMP:   cls = CL_JMP;
      OP_JZ:    cls = CL_JZ;
      OP_HALT:  cls = CL_HALT;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidad_control.sv
// rtl/unidad_control.sv - multi-cycle control FSM for the 14-bit ISA processor
module unidad_control
  import ctrl_pkg::*;
#(
  parameter int DW          = 14,
  parameter int OPW         = 4,
  parameter int MEM_TIMEOUT = 16
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [DW-1:0] ir,
  input  logic          zero,
  input  logic          mem_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic          addr_sel,
  output logic          pc_en,
  output logic          pc_sel,
  output logic          ir_en,
  output logic          acc_en,
  output logic [1:0]    acc_sel,
  output logic [2:0]    alu_op,
  output logic          busy,
  output logic          halted,
  output logic [1:0]    err_code
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state, state_next;
  logic [1:0]    err_q, err_next;
  logic [CW-1:0] cnt;
  cls_t          dec_cls;
  logic [2:0]    dec_alu;
  logic          dec_legal;
  logic          wait_st, timeout;
  state_t        next_fetch;
  logic          ir_unused;

  // Operand bits only feed the datapath muxes, never the control decisions.
  assign ir_unused = ^ir[DW-OPW-1:0];

  decodificador u_dec (
    .opcode (ir[DW-1 -: OPW]),
    .cls    (dec_cls),
    .alu_op (dec_alu),
    .legal  (dec_legal)
  );

  assign wait_st    = (state == ST_FETCH) || (state == ST_MEMRD) || (state == ST_MEMWR);
  assign timeout    = wait_st && !mem_ack && (cnt == CNT_LAST);
  // The instruction boundary is where run is honoured: no request is raised if it dropped.
  assign next_fetch = run ? ST_FETCH : ST_IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      err_q <= ERR_NONE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      err_q <= err_next;
      if (state_next != state)
        cnt <= '0;
      else if (wait_st && !mem_ack)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    err_next   = err_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = 1'b0;
    ir_en      = 1'b0;
    acc_en     = 1'b0;
    acc_sel    = ACC_SEL_ALU;
    alu_op     = ALU_ADD;
    busy       = 1'b1;
    halted     = 1'b0;
    err_code   = ERR_NONE;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = ST_LATCH;
        else if (timeout) begin state_next = ST_ERROR; err_next = ERR_TO; end
      end
      ST_LATCH: begin
        ir_en      = 1'b1;
        pc_en      = 1'b1;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (!dec_legal) begin
          state_next = ST_ERROR;
          err_next   = ERR_ILL;
        end else begin
          case (dec_cls)
            CL_NOP:   state_next = next_fetch;
            CL_LDI:   begin acc_en = 1'b1; acc_sel = ACC_SEL_IMM; state_next = next_fetch; end
            CL_JMP:   begin pc_en = 1'b1; pc_sel = 1'b1; state_next = next_fetch; end
            CL_JZ:    begin pc_en = zero; pc_sel = 1'b1; state_next = next_fetch; end
            CL_LOAD,
            CL_ALU:   state_next = ST_MEMRD;
            CL_STORE: state_next = ST_MEMWR;
            CL_HALT:  state_next = ST_HALTED;
            default:  begin state_next = ST_ERROR; err_next = ERR_ILL; end
          endcase
        end
      end
      ST_MEMRD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ack) state_next = ST_WB;
        else if (timeout) begin state_next = ST_ERROR; err_next = ERR_TO; end
      end
      ST_WB: begin
        acc_en = 1'b1;
        if (dec_cls == CL_LOAD) acc_sel = ACC_SEL_MEM;
        else alu_op = dec_alu;
        state_next = next_fetch;
      end
      ST_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ack) state_next = next_fetch;
        else if (timeout) begin state_next = ST_ERROR; err_next = ERR_TO; end
      end
      ST_HALTED: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      ST_ERROR: begin
        busy     = 1'b0;
        halted   = 1'b1;
        err_code = err_q;
      end
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_unidad_control.sv
// tb/tb_unidad_control.sv - scoreboard bench for unidad_control with directed per-cycle vectors
module tb_unidad_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [13:0] ir = '0;
  logic        zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, addr_sel, pc_en, pc_sel, ir_en, acc_en, busy, halted;
  logic [1:0]  acc_sel, err_code;
  logic [2:0]  alu_op;

  always #5 clk = ~clk;

  unidad_control #(.DW(14), .OPW(4), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .run(run), .ir(ir), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .pc_en(pc_en),
    .pc_sel(pc_sel), .ir_en(ir_en), .acc_en(acc_en), .acc_sel(acc_sel),
    .alu_op(alu_op), .busy(busy), .halted(halted), .err_code(err_code)
  );

  // Output bundle: req we addr_sel pc_en pc_sel ir_en acc_en acc_sel[2] alu_op[3] busy halted err[2]
  logic [15:0] act;
  assign act = {mem_req, mem_we, addr_sel, pc_en, pc_sel, ir_en, acc_en,
                acc_sel, alu_op, busy, halted, err_code};

  localparam logic [15:0] REQ = 16'h8000, WE = 16'h4000, AS = 16'h2000, PE = 16'h1000;
  localparam logic [15:0] PS = 16'h0800, IE = 16'h0400, AE = 16'h0200;
  localparam logic [15:0] ASEL_MEM = 16'h0080, ASEL_IMM = 16'h0100;
  localparam logic [15:0] AOP_SUB = 16'h0010, AOP_XOR = 16'h0040;
  localparam logic [15:0] BUSY = 16'h0008, HLT = 16'h0004, EILL = 16'h0001, ETO = 16'h0002;

  localparam logic [15:0] E_IDLE    = 16'h0000;
  localparam logic [15:0] E_FETCH   = REQ | BUSY;
  localparam logic [15:0] E_LATCH   = IE | PE | BUSY;
  localparam logic [15:0] E_DEC     = BUSY;
  localparam logic [15:0] E_DEC_LDI = AE | ASEL_IMM | BUSY;
  localparam logic [15:0] E_DEC_JMP = PE | PS | BUSY;
  localparam logic [15:0] E_DEC_JZN = PS | BUSY;
  localparam logic [15:0] E_MEMRD   = REQ | AS | BUSY;
  localparam logic [15:0] E_MEMWR   = REQ | WE | AS | BUSY;
  localparam logic [15:0] E_WB_LOAD = AE | ASEL_MEM | BUSY;
  localparam logic [15:0] E_WB_ADD  = AE | BUSY;
  localparam logic [15:0] E_WB_SUB  = AE | AOP_SUB | BUSY;
  localparam logic [15:0] E_WB_XOR  = AE | AOP_XOR | BUSY;
  localparam logic [15:0] E_HALT    = HLT;
  localparam logic [15:0] E_ERR_ILL = HLT | EILL;
  localparam logic [15:0] E_ERR_TO  = HLT | ETO;

  typedef struct {
    logic [15:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // c = {rst, run, mem_ack, zero}; e is what the outputs must show during this cycle.
  task automatic cyc(input logic [3:0] c, input logic [13:0] i, input logic [15:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    {rst, run, mem_ack, zero} = c;
    ir = i;
    x.v = e;
    x.name = nm;
    q.push_back(x);
  endtask

  task automatic front(input logic [13:0] i, input logic z, input logic [15:0] dec_e, input string nm);
    cyc({3'b011, z}, i, E_FETCH, {nm, "_fetch"});
    cyc({3'b011, z}, i, E_LATCH, {nm, "_latch"});
    cyc({3'b011, z}, i, dec_e,   {nm, "_decode"});
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        n_checks++;
        if (act === x.v) n_pass++;
        else $display("FAIL %s: outputs %h, expected %h", x.name, act, x.v);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    cyc(4'b1000, 14'h0000, E_IDLE, "rst0");
    cyc(4'b1000, 14'h0000, E_IDLE, "rst1");
    cyc(4'b0110, 14'h0000, E_IDLE, "idle_run");
    front(14'h0000, 1'b0, E_DEC,     "nop");
    front(14'h2005, 1'b0, E_DEC_LDI, "ldi");
    front(14'h2403, 1'b0, E_DEC_JMP, "jmp");
    front(14'h2800, 1'b1, E_DEC_JMP, "jz_taken");
    front(14'h2800, 1'b0, E_DEC_JZN, "jz_not");

    front(14'h0C05, 1'b0, E_DEC, "add");
    cyc(4'b0100, 14'h0C05, E_MEMRD,  "add_memrd_wait");
    cyc(4'b0110, 14'h0C05, E_MEMRD,  "add_memrd_ack");
    cyc(4'b0110, 14'h0C05, E_WB_ADD, "add_wb");
    front(14'h1000, 1'b0, E_DEC, "sub");
    cyc(4'b0110, 14'h1000, E_MEMRD,  "sub_memrd");
    cyc(4'b0110, 14'h1000, E_WB_SUB, "sub_wb");
    front(14'h1C00, 1'b0, E_DEC, "xor");
    cyc(4'b0110, 14'h1C00, E_MEMRD,  "xor_memrd");
    cyc(4'b0110, 14'h1C00, E_WB_XOR, "xor_wb");
    front(14'h0400, 1'b0, E_DEC, "load");
    cyc(4'b0110, 14'h0400, E_MEMRD,   "load_memrd");
    cyc(4'b0110, 14'h0400, E_WB_LOAD, "load_wb");
    front(14'h0800, 1'b0, E_DEC, "store");
    cyc(4'b0110, 14'h0800, E_MEMWR, "store_memwr");

    front(14'h0407, 1'b0, E_DEC, "rdrop");
    cyc(4'b0110, 14'h0407, E_MEMRD,   "rdrop_memrd");
    cyc(4'b0010, 14'h0407, E_WB_LOAD, "rdrop_wb");
    cyc(4'b0010, 14'h0407, E_IDLE,    "rdrop_boundary");
    cyc(4'b0110, 14'h0407, E_IDLE,    "rdrop_rerun");

    front(14'h0803, 1'b0, E_DEC, "strst");
    cyc(4'b0100, 14'h0803, E_MEMWR, "strst_wait");
    cyc(4'b1100, 14'h0803, E_MEMWR, "strst_rst");
    cyc(4'b0100, 14'h0803, E_IDLE,  "strst_after");

    for (int k = 0; k < 15; k++) cyc(4'b0100, 14'h0000, E_FETCH, "late_wait");
    cyc(4'b0110, 14'h0000, E_FETCH, "late_ack16");
    cyc(4'b0100, 14'h0000, E_LATCH, "late_latch");
    cyc(4'b0100, 14'h0000, E_DEC,   "late_decode");

    for (int k = 0; k < 16; k++) cyc(4'b0100, 14'h0000, E_FETCH, "to_fetch");
    cyc(4'b0000, 14'h0000, E_ERR_TO, "to_err");
    cyc(4'b0110, 14'h0000, E_ERR_TO, "to_sticky");
    cyc(4'b1110, 14'h0000, E_ERR_TO, "to_rst");
    cyc(4'b0110, 14'h0000, E_IDLE,   "to_idle");

    front(14'h3000, 1'b0, E_DEC, "ill");
    cyc(4'b0010, 14'h3000, E_ERR_ILL, "ill_err");
    cyc(4'b0110, 14'h3000, E_ERR_ILL, "ill_sticky");
    cyc(4'b1000, 14'h3000, E_ERR_ILL, "ill_rst");
    cyc(4'b0110, 14'h3000, E_IDLE,    "ill_idle");

    front(14'h3C00, 1'b0, E_DEC, "halt");
    cyc(4'b0000, 14'h3C00, E_HALT, "halt_state");
    cyc(4'b0110, 14'h3C00, E_HALT, "halt_sticky");
    cyc(4'b1000, 14'h3C00, E_HALT, "halt_rst");
    cyc(4'b0000, 14'h3C00, E_IDLE, "final_idle");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
